out_latency_checker: RTL
========================

# out_latency_checker

Synthesizable self-checking monitor for a registered-output block. It watches the 1-bit stimulus driven into the block under test and the block's 1-bit response, and verifies that the response equals the stimulus delayed by exactly `LATENCY` clock edges. It counts checks and mismatches, keeps a sticky error flag, and runs alongside the unit under test on FPGA/prototype builds, where a simulation testbench cannot be used.

## Interface

Parameters:

- `LATENCY`, 1: expected clock edges from `stim` sampled to `resp` valid; legal range 1..16.
- `CNT_WIDTH`, 16: width of the check and mismatch counters.

Ports:

- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: run checking; low returns the block to IDLE.
- `clear` input 1: synchronous clear of the counters and `err`.
- `stim` input 1: value driven into the unit under test (its `a`).
- `resp` input 1: unit-under-test output (its `out`).
- `armed` output 1: high while in CHECK.
- `err` output 1: sticky mismatch flag.
- `check_count` output CNT_WIDTH: number of comparisons performed.
- `mismatch_count` output CNT_WIDTH: number of failed comparisons.
- `first_err_cycle` output CNT_WIDTH: value of `check_count` at the first mismatch. Present only with `OUT_LATENCY_CHECKER_FIRST_ERR_EN`.

## Operation

- History shift register `hist[LATENCY-1:0]`: each edge, `hist[0] <= stim` and `hist[i] <= hist[i-1]`. It shifts in every state except reset.
- States:
  - IDLE: entered on reset, and whenever `enable` is low.
  - FILL: entered from IDLE at the first edge with `enable` high. A fill counter runs from 0; when it reaches `LATENCY-1` the state moves to CHECK at the next edge. FILL therefore lasts `LATENCY` edges.
  - CHECK: at each edge, compare `resp` against `hist[LATENCY-1]`:
    - `check_count` increments.
    - On inequality, `mismatch_count` increments and `err` is set.
- `enable` low in any state: go to IDLE at that edge with no comparison. Counters and `err` hold. Re-enabling always passes through FILL again.
- Counters saturate at all-ones and never wrap. `err` stays set even when `mismatch_count` is saturated.
- Priority order:
  - `rst` over everything.
  - `clear` over a comparison in the same edge: counters and `err` go to 0 and that edge's comparison is discarded. The state is unaffected.
- `resp` X/Z is not special-cased; any value other than 0 counts as 1 for synthesis.

## Timing

- Reset values:
  - state IDLE, `armed` 0, `err` 0.
  - `check_count` 0, `mismatch_count` 0, `first_err_cycle` 0.
  - `hist` all 0, fill counter 0.
- Enable to first check: `enable` rises before edge E0. FILL covers edges E0..E(LATENCY-1). The first comparison happens at edge E(LATENCY), and `armed` is high after edge E(LATENCY-1).
- Result latency: the counter and flag updates from the comparison at edge k are visible immediately after edge k.
- For `LATENCY`=1: the `resp` seen at edge k must equal the `stim` sampled at edge k-1. This matches a plain `out <= a` register.
- Reset mid-CHECK: all outputs return to their reset values after that edge, and the history is discarded.

## Configuration

- `OUT_LATENCY_CHECKER_FIRST_ERR_EN` defined:
  - On the first mismatch while `err` is 0, capture the pre-increment `check_count` into `first_err_cycle`.
  - Cleared to 0 by `rst`/`clear`.
- Undefined: `first_err_cycle` port and its register are absent, and everything else is identical.

## Test plan

- **Matched DUT.** `LATENCY`=1, `resp` driven by a register of `stim`, reset 2 cycles, `enable`=1, `stim` = 0,0,1,1,0 then held → `err`=0. After 10 check edges, `check_count`=10 and `mismatch_count`=0.
- **Stuck-at fault.** `resp` forced to 0 and `stim` held at 1 for 5 check edges → `mismatch_count`=5 and `err`=1. With the macro, `first_err_cycle`=0.
- **Wrong latency.** `LATENCY`=2 against a 1-cycle register, `stim` toggling every cycle → every check mismatches; `mismatch_count` equals `check_count`.
- **Fill gating.** `LATENCY`=3, `enable` rises before E0 → `armed` goes high after E2, and `check_count` is 0 until after E3, then 1.
- **Clear and disable.** After 3 mismatches, pulse `clear` one cycle → counters 0 and `err`=0, state still CHECK. Drop `enable` → `armed`=0 and the counters hold across 5 cycles.
- **Saturation and reset.** `CNT_WIDTH`=4 with 20 mismatches → `mismatch_count`=15. Assert `rst` mid-CHECK → all outputs 0 after the edge.

Source files
------------

// File: rtl/out_latency_checker.sv
// rtl/out_latency_checker.sv - Self-checking latency monitor for a registered 1-bit block
//
// Watches the stimulus fed into a unit under test and that unit's response.
// It checks that the response equals the stimulus delayed by exactly LATENCY
// clock edges. Checks and mismatches are counted, and a sticky error flag is
// kept.
//
// Parameters:
//   LATENCY    expected stim-to-resp delay in clock edges (1..16)
//   CNT_WIDTH  width of the check/mismatch counters
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   enable           run checking; low returns to IDLE (counters hold)
//   clear            synchronous clear of counters, err and first_err_cycle
//   stim             value driven into the unit under test
//   resp             unit-under-test output
//   armed            high while comparisons are being made (CHECK state)
//   err              sticky mismatch flag
//   check_count      saturating count of comparisons performed
//   mismatch_count   saturating count of failed comparisons
//   first_err_cycle  check_count value at the first mismatch
//                    (only with OUT_LATENCY_CHECKER_FIRST_ERR_EN defined)
//
// Optional feature macro: OUT_LATENCY_CHECKER_FIRST_ERR_EN

module out_latency_checker #(
   parameter int LATENCY   = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 clear,
   input  logic                 stim,
   input  logic                 resp,
   output logic                 armed,
   output logic                 err,
   output logic [CNT_WIDTH-1:0] check_count,
`ifdef OUT_LATENCY_CHECKER_FIRST_ERR_EN
   output logic [CNT_WIDTH-1:0] mismatch_count,
   output logic [CNT_WIDTH-1:0] first_err_cycle
`else
   output logic [CNT_WIDTH-1:0] mismatch_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   // Fill counter counts FILL edges, including the IDLE->FILL edge itself,
   // so that CHECK is reached after exactly LATENCY edges.
   localparam logic [4:0]           FILL_LAST = 5'(LATENCY - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   state_t             state;
   logic [4:0]         fill_cnt;
   logic [LATENCY-1:0] hist;
   logic               do_check;
   logic               mismatch;

   // A comparison happens only in CHECK with enable high; clear discards it.
   always_comb begin
      do_check = 1'b0;
      mismatch = 1'b0;
      do_check = (state == S_CHECK) && enable && !clear;
      mismatch = (resp != hist[LATENCY-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         armed          <= 1'b0;
         fill_cnt       <= '0;
         hist           <= '0;
         err            <= 1'b0;
         check_count    <= '0;
         mismatch_count <= '0;
`ifdef OUT_LATENCY_CHECKER_FIRST_ERR_EN
         first_err_cycle <= '0;
`endif
      end else begin
         // History shifts every edge regardless of state.
         hist[0] <= stim;
         for (int i = 1; i < LATENCY; i++) begin
            hist[i] <= hist[i-1];
         end

         // State machine
         if (!enable) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            fill_cnt <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (FILL_LAST == 5'd0) begin
                     state    <= S_CHECK;
                     armed    <= 1'b1;
                     fill_cnt <= '0;
                  end else begin
                     state    <= S_FILL;
                     armed    <= 1'b0;
                     fill_cnt <= 5'd1;
                  end
               end
               S_FILL: begin
                  if (fill_cnt == FILL_LAST) begin
                     state    <= S_CHECK;
                     armed    <= 1'b1;
                     fill_cnt <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + 5'd1;
                  end
               end
               S_CHECK: begin
                  state <= S_CHECK;
                  armed <= 1'b1;
               end
               default: begin
                  state    <= S_IDLE;
                  armed    <= 1'b0;
                  fill_cnt <= '0;
               end
            endcase
         end

         // Result counters: clear wins over a same-edge comparison.
         if (clear) begin
            err            <= 1'b0;
            check_count    <= '0;
            mismatch_count <= '0;
`ifdef OUT_LATENCY_CHECKER_FIRST_ERR_EN
            first_err_cycle <= '0;
`endif
         end else if (do_check) begin
            if (check_count != CNT_MAX) begin
               check_count <= check_count + 1'b1;
            end
            if (mismatch) begin
               err <= 1'b1;
               if (mismatch_count != CNT_MAX) begin
                  mismatch_count <= mismatch_count + 1'b1;
               end
`ifdef OUT_LATENCY_CHECKER_FIRST_ERR_EN
               // Capture pre-increment count only for the first error.
               if (!err) begin
                  first_err_cycle <= check_count;
               end
`endif
            end
         end
      end
   end

endmodule
